// File: rtl/exe_sequencer.sv
// Instruction sequencer: fetches, decodes and issues ops to exe_engine.
// Optional single-step support under EXE_SEQUENCER_STEP_EN.
module exe_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic            op_valid,
    output logic [3:0]      opcode,
    output logic [3:0]      dest,
    output logic [3:0]      src1,
    output logic [3:0]      src2,
    input  logic            unit_done,
`ifdef EXE_SEQUENCER_STEP_EN
    input  logic            step_mode,
    input  logic            step,
`endif
    output logic            busy,
    output logic            halted,
    output logic            error,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
`ifdef EXE_SEQUENCER_STEP_EN
        S_PAUSE,
`endif
        S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     retired_q, retired_d;
    logic [15:0]     timer_q, timer_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [3:0]      dest_q, dest_d;
    logic [3:0]      src1_q, src1_d;
    logic [3:0]      src2_q, src2_d;
    logic            op_valid_q, op_valid_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;
    logic            error_q, error_d;
    logic            retire;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        timer_d   = timer_q;
        opcode_d  = opcode_q;
        dest_d    = dest_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        error_d   = error_q;
        retire    = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                    error_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (imem_data[15:12] == 4'h0) begin
                    retire = 1'b1;
                end else if (imem_data[15:12] == 4'hF) begin
                    state_d = S_HALT;
                end else begin
                    opcode_d = imem_data[15:12];
                    dest_d   = imem_data[11:8];
                    src1_d   = imem_data[7:4];
                    src2_d   = imem_data[3:0];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done on the final timer cycle still wins over the watchdog
                if (unit_done) begin
                    retire = 1'b1;
                end else if (timer_q == 16'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`ifdef EXE_SEQUENCER_STEP_EN
            S_PAUSE: begin
                if (step || !step_mode) state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            pc_d = pc_q + PC_W'(1);
            if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
            state_d = S_FETCH;
`ifdef EXE_SEQUENCER_STEP_EN
            if (step_mode) state_d = S_PAUSE;
`endif
        end

        op_valid_d = (state_d == S_ISSUE);
        halted_d   = (state_d == S_HALT);
        busy_d     = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                     (state_d == S_ISSUE) || (state_d == S_WAIT);
`ifdef EXE_SEQUENCER_STEP_EN
        if (state_d == S_PAUSE) busy_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            retired_q  <= '0;
            timer_q    <= '0;
            opcode_q   <= '0;
            dest_q     <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            timer_q    <= timer_d;
            opcode_q   <= opcode_d;
            dest_q     <= dest_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            error_q    <= error_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign opcode    = opcode_q;
    assign dest      = dest_q;
    assign src1      = src1_q;
    assign src2      = src2_q;
    assign op_valid  = op_valid_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign error     = error_q;

endmodule

// File: tb/tb_exe_sequencer.sv
// Scoreboard bench for exe_sequencer: program-level model feeds expected
// issues and final halt state; a monitor checks them as the DUT produces them.
module tb_exe_sequencer;
    localparam int PC_W    = 4;
    localparam int TIMEOUT = 8;
    localparam int MEMN    = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start_drv = 1'b0;
    logic            start_noise = 1'b0;
    logic            start;
    logic            unit_done = 1'b0;
    logic [PC_W-1:0] imem_addr, pc;
    logic [15:0]     imem_data, retired;
    logic            op_valid, busy, halted, error;
    logic [3:0]      opcode, dest, src1, src2;
`ifdef EXE_SEQUENCER_STEP_EN
    logic            step_mode = 1'b0;
    logic            step = 1'b0;
`endif

    assign start = start_drv | start_noise;

    exe_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .op_valid(op_valid), .opcode(opcode), .dest(dest),
        .src1(src1), .src2(src2), .unit_done(unit_done),
`ifdef EXE_SEQUENCER_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .busy(busy), .halted(halted), .error(error),
        .pc(pc), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [MEMN];
    always @(posedge clk) imem_data <= mem[imem_addr];

    typedef struct {int pc; int ret; int err;} end_t;
    logic [15:0] exp_op_q [$];
    int          lat_q [$];
    end_t        exp_end_q [$];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint issue_cyc = 0;
    logic   prev_halted = 1'b0;
    bit     noise_en = 1'b0;
    int     done_cnt = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pops expectations when the DUT issues or halts
    always @(negedge clk) begin
        logic [15:0] w;
        end_t e;
        if (!reset) begin
            if (op_valid) begin
                issue_cyc = cyc;
                chk("op_expected", exp_op_q.size() > 0, 1);
                if (exp_op_q.size() > 0) begin
                    w = exp_op_q.pop_front();
                    chk("op_fields", {opcode, dest, src1, src2}, w);
                end
            end
            if (halted && !prev_halted) begin
                chk("halt_expected", exp_end_q.size() > 0, 1);
                if (exp_end_q.size() > 0) begin
                    e = exp_end_q.pop_front();
                    chk("halt_pc", pc, e.pc);
                    chk("halt_retired", retired, e.ret);
                    chk("halt_error", error, e.err);
                    if (e.err != 0)
                        chk("wdog_latency", cyc - issue_cyc, TIMEOUT + 1);
                end
            end
        end
        prev_halted = halted;
    end

    // unit model: done d cycles after op_valid; 0 = during ISSUE, <0 = never
    always @(negedge clk) begin
        int d;
        if (reset) begin
            done_cnt = 0;
            unit_done = 1'b0;
        end else begin
            unit_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) unit_done = 1'b1;
            end
            if (op_valid && lat_q.size() > 0) begin
                d = lat_q.pop_front();
                if (d == 0) unit_done = 1'b1;
                else if (d > 0) done_cnt = d;
            end
        end
    end

    always @(negedge clk)
        start_noise = noise_en && busy && ($urandom_range(0, 5) == 0);

    function automatic int gen_lat();
        int r = $urandom_range(0, 19);
        if (r == 0) return 0;
        if (r == 1) return TIMEOUT + $urandom_range(1, 3);
        return $urandom_range(1, TIMEOUT);
    endfunction

    // program-level reference: walk memory, retire or time out per op
    task automatic model_prog(bit rnd, int fixed_lat);
        int p = 0, r = 0, e = 0, d;
        bit fin = 0;
        logic [15:0] w;
        for (int n = 0; n < 64 && !fin; n++) begin
            w = mem[p];
            if (w[15:12] == 4'h0) begin
                p = (p + 1) % MEMN;
                r = (r < 65535) ? r + 1 : r;
            end else if (w[15:12] == 4'hF) begin
                fin = 1;
            end else begin
                d = rnd ? gen_lat() : fixed_lat;
                lat_q.push_back(d);
                exp_op_q.push_back(w);
                if (d >= 1 && d <= TIMEOUT) begin
                    p = (p + 1) % MEMN;
                    r = (r < 65535) ? r + 1 : r;
                end else begin
                    e = 1;
                    fin = 1;
                end
            end
        end
        exp_end_q.push_back('{p, r, e});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_op_q.delete();
        lat_q.delete();
        exp_end_q.delete();
    endtask

    task automatic run_prog(int budget);
        int n = 0;
        bit is_op;
        is_op = (mem[0][15:12] != 4'h0) && (mem[0][15:12] != 4'hF);
        @(negedge clk);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        chk("fetch_addr", imem_addr, 0);
        chk("fetch_busy", busy, 1);
        chk("fetch_error_clr", error, 0);
        @(negedge clk);
        chk("decode_opv", op_valid, 0);
        @(negedge clk);
        chk("issue_opv", op_valid, is_op);
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", halted, 1);
        if (!halted) begin
            do_reset();
        end else begin
            repeat (4) @(negedge clk);
            chk("ops_drained", exp_op_q.size(), 0);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEMN; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        clear_mem();
        #2 reset = 1'b1;
        #1;
        chk("rst_opv", op_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error", error, 0);
        chk("rst_pc", pc, 0);
        chk("rst_retired", retired, 0);
        chk("rst_fields", {opcode, dest, src1, src2}, 0);
        @(negedge clk);
        reset = 1'b0;

        mem[0] = 16'h1123; mem[1] = 16'h0000;
        mem[2] = 16'h2456; mem[3] = 16'hF000;
        model_prog(0, 2);
        run_prog(300);
        chk("plan_pc", pc, 3);
        chk("plan_retired", retired, 3);

        clear_mem();
        mem[0] = 16'h1123; mem[1] = 16'hF000;
        model_prog(0, -1);
        run_prog(300);
        chk("wdog_error", error, 1);
        chk("wdog_pc", pc, 0);
        chk("wdog_retired", retired, 0);

        model_prog(0, 0);
        run_prog(300);
        chk("issue_done_error", error, 1);

        noise_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < MEMN; i++) begin
                int r = $urandom_range(0, 9);
                logic [15:0] w = 16'($urandom);
                if (r < 3) w[15:12] = 4'h0;
                else if (r == 9) w[15:12] = 4'hF;
                else w[15:12] = 4'($urandom_range(1, 14));
                mem[i] = w;
            end
            mem[$urandom_range(1, MEMN - 1)] = 16'hF000;
            model_prog(1, 0);
            run_prog(600);
        end
        noise_en = 1'b0;

        clear_mem();
        mem[0] = 16'h1123; mem[1] = 16'hF000;
        model_prog(0, -1);
        @(negedge clk);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_opv", op_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_halted", halted, 0);
        chk("abort_pc", pc, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_op_q.delete();
        lat_q.delete();
        exp_end_q.delete();
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_halted", halted, 0);

        clear_mem();
        exp_end_q.push_back('{3, 19, 0});
        fork
            run_prog(300);
            begin
                repeat (20) @(negedge clk);
                mem[3] = 16'hF000;
            end
        join

`ifdef EXE_SEQUENCER_STEP_EN
        clear_mem();
        mem[1] = 16'hF000;
        exp_end_q.push_back('{1, 1, 0});
        step_mode = 1'b1;
        @(negedge clk);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (6) @(negedge clk);
        chk("pause_busy", busy, 1);
        chk("pause_pc", pc, 1);
        chk("pause_retired", retired, 1);
        chk("pause_halted", halted, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        step_mode = 1'b0;
        repeat (6) @(negedge clk);
        chk("step_halted", halted, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
